// File: rtl/mysystem_pio_pkg.sv
// Shared definitions for the system PIO blocks: register offsets and
// edge-capture selection encodings.
`timescale 1ns/1ps
package mysystem_pio_pkg;

  // Register offsets within the 2-bit PIO address window
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Which transition of a debounced line sets its edge-capture bit
  typedef enum logic [1:0] {
    EDGE_FALLING = 2'd0,
    EDGE_RISING  = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  // One-bit edge qualifier: cur is the current debounced level, prev the
  // level one cycle earlier.
  function automatic logic edge_hit(input edge_type_e sel,
                                    input logic cur,
                                    input logic prev);
    logic hit;
    case (sel)
      EDGE_FALLING: hit = prev & ~cur;
      EDGE_RISING:  hit = cur & ~prev;
      EDGE_ANY:     hit = cur ^ prev;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mysystem_keys_pio_key_debounce.sv
// Single-line key conditioner: two-flop synchronizer followed by a
// stability counter. The output only moves after the synchronized input has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
`timescale 1ns/1ps
module key_debounce #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Synchronize the raw pin and advance the stability counter; the counter
  // restarts whenever the synchronized level agrees with the accepted one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= IDLE_LEVEL;
      r_sync2  <= IDLE_LEVEL;
      r_stable <= IDLE_LEVEL;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_stable) begin
        if (r_cnt >= CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/mysystem_keys_pio.sv
// Avalon-MM key/switch input port: debounced data, interrupt mask and a
// sticky write-1-to-clear edge-capture register driving a level interrupt.
`timescale 1ns/1ps
module mysystem_keys_pio
  import mysystem_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_wr_mask;
  logic             w_wr_edgecap;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_stable_prev;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      r_readdata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL[gi])
    ) u_key (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_raw    (in_port[gi]),
      .o_stable (w_stable[gi])
    );
  end

  // Write strobes; data and reserved offsets have no writable state
  assign w_wr_mask    = chipselect & ~write_n & (address == ADDR_IRQMASK);
  assign w_wr_edgecap = chipselect & ~write_n & (address == ADDR_EDGECAP);

  // Upper write-data bits have no destination when WIDTH < 32
  assign w_unused_wdata = ^writedata;

  // Qualify per-bit transitions of the debounced level
  always_comb begin
    w_edge = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_edge[i] = edge_hit(EDGE_SEL, w_stable[i], r_stable_prev[i]);
    end
  end

  // Bits to clear in the edge-capture register this cycle
  always_comb begin
    if (w_wr_edgecap) begin
      w_clr = writedata[WIDTH-1:0];
    end else begin
      w_clr = '0;
    end
  end

  // Read multiplexer, zero-extended to the bus width
  always_comb begin
    w_rd_mux = 32'h0000_0000;
    case (address)
      ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_stable;
      ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
      ADDR_RSVD:    w_rd_mux = 32'h0000_0000;
      ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
      default:      w_rd_mux = 32'h0000_0000;
    endcase
  end

  // Previous debounced level for edge detection; starts at idle so reset
  // release never looks like an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_prev <= IDLE_LEVEL;
    end else begin
      r_stable_prev <= w_stable;
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
    end else if (w_wr_mask) begin
      r_irqmask <= writedata[WIDTH-1:0];
    end else begin
      r_irqmask <= r_irqmask;
    end
  end

  // Sticky edge capture; a new edge in the same cycle as its clear survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
    end
  end

  // Registered read data, updated every cycle regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'h0000_0000;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_mysystem_keys_pio.sv
// Scoreboard bench for mysystem_keys_pio with default parameters
// (WIDTH 4, 16-cycle debounce, falling-edge capture, idle high).
`timescale 1ns/1ps
module tb_mysystem_keys_pio;
  import mysystem_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  mysystem_keys_pio dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  // Read data is valid one clock after the address is presented
  always @(posedge clk) rd_vld <= rd_req;

  // Monitor: pop the oldest expectation whenever a read result is presented
  always @(negedge clk) begin
    if (rd_vld) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: readdata=%h with no expectation queued", readdata);
      end else begin
        mon_e = sb_q.pop_front();
        total++;
        if (readdata !== mon_e.data) begin
          bad++;
          $display("FAIL %s data: got %h want %h", mon_e.name, readdata, mon_e.data);
        end
        total++;
        if (irq !== mon_e.irq) begin
          bad++;
          $display("FAIL %s irq: got %b want %b", mon_e.name, irq, mon_e.irq);
        end
      end
    end
  end

  task automatic do_read(input string nm, input logic [1:0] a,
                         input logic [31:0] exp_d, input logic exp_irq);
    exp_t e;
    @(negedge clk);
    address = a;
    rd_req = 1'b1;
    e.name = nm;
    e.data = exp_d;
    e.irq = exp_irq;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic [3:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  initial begin
    // Reset state
    cycles(3);
    @(negedge clk);
    reset_n = 1'b1;
    do_read("rst_data", ADDR_DATA, 32'h0000_000F, 1'b0);
    do_read("rst_mask", ADDR_IRQMASK, 32'h0, 1'b0);
    do_read("rst_edgecap", ADDR_EDGECAP, 32'h0, 1'b0);
    do_read("rst_rsvd", ADDR_RSVD, 32'h0, 1'b0);

    // Clean falling step on bit 1: stable moves on edge 18 after the step
    set_pins(4'hD);
    cycles(16);
    do_read("step_before", ADDR_DATA, 32'h0000_000F, 1'b0);   // edge 17
    cycles(1);                                                 // edge 18
    do_read("step_after", ADDR_DATA, 32'h0000_000D, 1'b0);    // edge 19
    do_read("step_edgecap", ADDR_EDGECAP, 32'h2, 1'b0);
    cycles(10);
    do_read("step_hold", ADDR_DATA, 32'h0000_000D, 1'b0);
    do_write(ADDR_IRQMASK, 32'h2);
    do_read("mask_irq", ADDR_IRQMASK, 32'h2, 1'b1);

    // Release back to idle: rising edge is not captured
    set_pins(4'hF);
    cycles(25);
    do_read("release_data", ADDR_DATA, 32'h0000_000F, 1'b1);
    do_read("release_edgecap", ADDR_EDGECAP, 32'h2, 1'b1);

    // Write-1-to-clear
    do_write(ADDR_EDGECAP, 32'h2);
    do_read("w1c_edgecap", ADDR_EDGECAP, 32'h0, 1'b0);

    // Bounce on bit 0 shorter than the debounce window
    for (int k = 0; k < 8; k++) begin
      set_pins({3'b111, k[0]});
      cycles(4);
    end
    set_pins(4'hF);
    cycles(25);
    do_read("bounce_data", ADDR_DATA, 32'h0000_000F, 1'b0);
    do_read("bounce_edgecap", ADDR_EDGECAP, 32'h0, 1'b0);

    // Falling edge on bit 2 coincides with a clear of bit 2: set wins
    set_pins(4'hB);
    cycles(18);
    do_write(ADDR_EDGECAP, 32'h4);                             // edge 19
    do_read("setwins_edgecap", ADDR_EDGECAP, 32'h4, 1'b0);
    do_read("setwins_data", ADDR_DATA, 32'h0000_000B, 1'b0);
    do_write(ADDR_EDGECAP, 32'h2);
    do_read("w1c_other_bit", ADDR_EDGECAP, 32'h4, 1'b0);
    do_write(ADDR_IRQMASK, 32'h6);
    do_read("mask6_irq", ADDR_EDGECAP, 32'h4, 1'b1);
    set_pins(4'hF);
    cycles(25);

    // Reset in the middle of a debounce on bit 3, input idle at release
    set_pins(4'h7);
    cycles(12);
    reset_n = 1'b0;
    in_port = 4'hF;
    cycles(3);
    @(negedge clk);
    reset_n = 1'b1;
    do_read("midrst_data", ADDR_DATA, 32'h0000_000F, 1'b0);
    do_read("midrst_edgecap", ADDR_EDGECAP, 32'h0, 1'b0);
    do_read("midrst_mask", ADDR_IRQMASK, 32'h0, 1'b0);
    cycles(25);
    do_read("midrst_settled", ADDR_DATA, 32'h0000_000F, 1'b0);
    do_read("midrst_noedge", ADDR_EDGECAP, 32'h0, 1'b0);

    // Register width and read-only / reserved writes
    do_write(ADDR_IRQMASK, 32'hFFFF_FFFF);
    do_read("mask_width", ADDR_IRQMASK, 32'h0000_000F, 1'b0);
    do_write(ADDR_IRQMASK, 32'h5);
    do_write(ADDR_DATA, 32'hFF);
    do_write(ADDR_RSVD, 32'hFF);
    do_read("ro_data", ADDR_DATA, 32'h0000_000F, 1'b0);
    do_read("ro_rsvd", ADDR_RSVD, 32'h0, 1'b0);
    do_read("ro_mask", ADDR_IRQMASK, 32'h5, 1'b0);

    cycles(3);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
